// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: default width and FSM encoding.
package seq_divider_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned STATE_W   = 2;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_CALC = 2'd1;
  localparam state_t S_DONE = 2'd2;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor,
// keep the difference when it does not borrow.
module seq_divider_div_step
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] r,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic             q_bit
);

  localparam int unsigned EXT_W = WIDTH + 1;

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Partial remainder is always below the divisor, so its extra top bit is implicitly zero.
  assign shifted = {r, q_msb};
  assign diff    = shifted + ~{1'b0, d} + EXT_W'(1);
  assign q_bit   = ~diff[WIDTH];
  assign r_next  = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Unsigned iterative restoring divider with start/busy/done handshake, one quotient bit per clock.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t state;
  state_t state_next;

  logic             accept_c;
  logic             step_c;
  logic             last_c;
  logic             zero_c;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] r_next;
  logic             q_bit;

  seq_divider_div_step #(.WIDTH(WIDTH)) u_step (
    .r      (r_q),
    .q_msb  (q_q[WIDTH-1]),
    .d      (d_q),
    .r_next (r_next),
    .q_bit  (q_bit)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next = (divisor == '0) ? S_DONE : S_CALC;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_CALC: begin
        if (cnt == LAST_STEP) begin
          state_next = S_DONE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Control strobes decoded from the current state
  always_comb begin
    accept_c = 1'b0;
    step_c   = 1'b0;
    last_c   = 1'b0;
    zero_c   = (divisor == '0);
    case (state)
      S_IDLE, S_DONE: accept_c = start;
      S_CALC: begin
        step_c = 1'b1;
        last_c = (cnt == LAST_STEP);
      end
      default: ;
    endcase
  end

  // Datapath and registered outputs; results only move on acceptance (div-by-zero) or the last step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      busy <= (state_next == S_CALC);
      done <= (state_next == S_DONE);
      if (accept_c) begin
        d_q <= divisor;
        q_q <= dividend;
        r_q <= '0;
        cnt <= '0;
        if (zero_c) begin
          quotient    <= '1;
          remainder   <= dividend;
          div_by_zero <= 1'b1;
        end else begin
          div_by_zero <= 1'b0;
        end
      end else if (step_c) begin
        r_q <= r_next;
        q_q <= {q_q[WIDTH-2:0], q_bit};
        cnt <= cnt + CNT_W'(1);
        if (last_c) begin
          quotient  <= {q_q[WIDTH-2:0], q_bit};
          remainder <= r_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=4): directed scenarios, exhaustive sweep,
// and random back-to-back traffic against an arithmetic reference model.
module tb_seq_divider;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division, with the all-ones/dividend rule for a zero divisor.
  task automatic ref_div(input int a, input int b, output int q, output int r, output int z);
    if (b == 0) begin
      q = (1 << W) - 1;
      r = a;
      z = 1;
    end else begin
      q = a / b;
      r = a % b;
      z = 0;
    end
  endtask

  // Called at a falling edge: present operands, let the next rising edge accept them.
  task automatic launch(input int a, input int b);
    start    = 1'b1;
    dividend = W'(a);
    divisor  = W'(b);
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
  endtask

  // Wait (bounded) for done, then check latency and results. lat0 = edges already elapsed since acceptance.
  task automatic wait_check(input int a, input int b, input string tag, input int lat0);
    int lat;
    int eq, er, ez;
    int exp_lat;
    lat = lat0;
    exp_lat = (b == 0) ? 0 : W;
    ref_div(a, b, eq, er, ez);
    while (done !== 1'b1 && lat < 12) begin
      check({tag, "_busy"}, 32'(busy), 32'd1);
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_quotient"}, 32'(quotient), 32'(eq));
    check({tag, "_remainder"}, 32'(remainder), 32'(er));
    check({tag, "_dbz"}, 32'(div_by_zero), 32'(ez));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int a, b, eq, er, ez;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_quotient", 32'(quotient), 32'd0);
    check("reset_remainder", 32'(remainder), 32'd0);
    check("reset_dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 13/3 with busy/done timing and one-cycle done pulse
    launch(13, 3);
    check("d13_3_busy_after_accept", 32'(busy), 32'd1);
    wait_check(13, 3, "d13_3", 0);
    @(negedge clk);
    check("d13_3_done_pulse", 32'(done), 32'd0);
    check("d13_3_quotient_held", 32'(quotient), 32'd4);

    launch(15, 1); wait_check(15, 1, "d15_1", 0); @(negedge clk);
    launch(7, 9);  wait_check(7, 9, "d7_9", 0);   @(negedge clk);
    launch(0, 5);  wait_check(0, 5, "d0_5", 0);   @(negedge clk);

    // Divide by zero, then a normal op must clear the flag
    launch(9, 0);  wait_check(9, 0, "d9_0", 0);   @(negedge clk);
    check("d9_0_done_pulse", 32'(done), 32'd0);
    check("d9_0_dbz_held", 32'(div_by_zero), 32'd1);
    launch(8, 2);  wait_check(8, 2, "d8_2", 0);   @(negedge clk);

    // Start during CALC must be ignored
    start    = 1'b1;
    dividend = W'(13);
    divisor  = W'(3);
    @(posedge clk);
    @(negedge clk);
    start    = 1'b1;
    dividend = W'(2);
    divisor  = W'(1);
    @(negedge clk);
    start    = 1'b0;
    wait_check(13, 3, "ignore_mid_calc", 1);
    @(negedge clk);
    check("ignore_no_second_op", 32'(busy), 32'd0);

    // Back-to-back: start held in the done cycle
    launch(12, 5);
    wait_check(12, 5, "b2b_first", 0);
    launch(14, 3);
    wait_check(14, 3, "b2b_second", 0);
    @(negedge clk);

    // Asynchronous reset in the middle of an operation
    launch(13, 3);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_quotient", 32'(quotient), 32'd0);
    check("arst_remainder", 32'(remainder), 32'd0);
    check("arst_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_idle", 32'(busy), 32'd0);
    launch(11, 4); wait_check(11, 4, "after_reset", 0); @(negedge clk);

    // Exhaustive operand sweep
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        launch(i, j);
        wait_check(i, j, "sweep", 0);
        @(negedge clk);
      end
    end

    // Random traffic, sometimes chained straight off the done cycle
    for (int k = 0; k < 60; k++) begin
      a = int'($urandom_range(0, 15));
      b = (($urandom_range(0, 7)) == 0) ? 0 : int'($urandom_range(1, 15));
      launch(a, b);
      wait_check(a, b, "random", 0);
      if ($urandom_range(0, 1) == 0) begin
        @(negedge clk);
        ref_div(a, b, eq, er, ez);
        check("random_hold_quotient", 32'(quotient), 32'(eq));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
